// File: rtl/srio_swrite_segmenter_if.sv
// rtl/srio_swrite_segmenter_if.sv - stream handshake bundle for the SWRITE segmenter
interface srio_swrite_segmenter_if #(
  parameter int DATA_W = 64,
  parameter int USER_W = 32
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;
  logic [USER_W-1:0] tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/srio_swrite_segmenter.sv
// rtl/srio_swrite_segmenter.sv - cuts a 64-bit stream frame into HELLO-headed SRIO write packets
module srio_swrite_segmenter #(
  parameter int MAX_BEATS = 32,
  parameter int ADDR_W    = 34,
  parameter int SEG_W     = 6
) (
  input  logic                    AXIS_ACLK,
  input  logic                    AXIS_ARESETN,
  input  logic [ADDR_W-1:0]       cfg_base_addr,
  input  logic [31:0]             cfg_srcdest,
  input  logic [1:0]              cfg_mode,
  input  logic [1:0]              cfg_prio,
  input  logic [SEG_W-1:0]        cfg_seg_beats,
  srio_swrite_segmenter_if.slave  s_axis,
  srio_swrite_segmenter_if.master m_axis,
  output logic                    busy,
  output logic [31:0]             stat_pkt_count
);
  typedef enum logic [1:0] {ST_FILL, ST_HDR, ST_DATA} state_t;

  localparam int IDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [SEG_W-1:0] MAX_LEN = SEG_W'(MAX_BEATS);

  state_t            state_q, state_d;
  logic              rdy_en_q, rdy_en_d;
  logic              frame_start_q, frame_start_d;
  logic              busy_q, busy_d;
  logic              last_seg_q, last_seg_d;
  logic [SEG_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [SEG_W-1:0]  out_idx_q, out_idx_d;
  logic [SEG_W-1:0]  seg_len_q, seg_len_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [31:0]       srcdest_q, srcdest_d;
  logic [31:0]       pkt_cnt_q, pkt_cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic [1:0]        prio_q, prio_d;
  logic [7:0]        tid_q, tid_d;
  logic [63:0]       mem_q [MAX_BEATS];

  logic              wr_en;
  logic [SEG_W-1:0]  cfg_len, cur_len;
  logic [3:0]        ftype, ttype;
  logic [8:0]        bytes;
  logic [63:0]       hdr;

  // Segment length comes straight from cfg until the frame's first beat freezes it.
  always_comb begin
    cfg_len = (cfg_seg_beats == '0 || cfg_seg_beats > MAX_LEN) ? MAX_LEN : cfg_seg_beats;
    cur_len = frame_start_q ? cfg_len : seg_len_q;
    case (mode_q)
      2'd1:    begin ftype = 4'd5; ttype = 4'd4; end
      2'd2:    begin ftype = 4'd5; ttype = 4'd5; end
      default: begin ftype = 4'd6; ttype = 4'd0; end
    endcase
    bytes = 9'({beat_cnt_q, 3'b000});
    hdr   = {tid_q, ftype, ttype, 1'b0, prio_q, 1'b0, 8'(bytes - 9'd1), 2'b00, 34'(cur_addr_q)};
  end

  always_comb begin
    state_d       = state_q;
    rdy_en_d      = 1'b1;
    frame_start_d = frame_start_q;
    busy_d        = busy_q;
    last_seg_d    = last_seg_q;
    beat_cnt_d    = beat_cnt_q;
    out_idx_d     = out_idx_q;
    seg_len_d     = seg_len_q;
    cur_addr_d    = cur_addr_q;
    srcdest_d     = srcdest_q;
    pkt_cnt_d     = pkt_cnt_q;
    mode_d        = mode_q;
    prio_d        = prio_q;
    tid_d         = tid_q;
    wr_en         = 1'b0;
    s_axis.tready = 1'b0;
    m_axis.tvalid = 1'b0;
    m_axis.tlast  = 1'b0;
    m_axis.tdata  = '0;
    case (state_q)
      ST_FILL: begin
        s_axis.tready = rdy_en_q && (beat_cnt_q < cur_len);
        if (s_axis.tready && s_axis.tvalid) begin
          wr_en      = 1'b1;
          beat_cnt_d = beat_cnt_q + SEG_W'(1);
          if (frame_start_q) begin
            cur_addr_d    = cfg_base_addr;
            srcdest_d     = cfg_srcdest;
            mode_d        = cfg_mode;
            prio_d        = cfg_prio;
            seg_len_d     = cfg_len;
            frame_start_d = 1'b0;
            busy_d        = 1'b1;
          end
          if (beat_cnt_q + SEG_W'(1) == cur_len || s_axis.tlast) begin
            last_seg_d = s_axis.tlast;
            state_d    = ST_HDR;
          end
        end
      end
      ST_HDR: begin
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = hdr;
        if (m_axis.tready) begin
          out_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      default: begin
        m_axis.tvalid = 1'b1;
        m_axis.tdata  = mem_q[out_idx_q[IDX_W-1:0]];
        m_axis.tlast  = (out_idx_q + SEG_W'(1) == beat_cnt_q);
        if (m_axis.tready) begin
          out_idx_d = out_idx_q + SEG_W'(1);
          if (m_axis.tlast) begin
            tid_d      = tid_q + 8'd1;
            pkt_cnt_d  = pkt_cnt_q + 32'd1;
            cur_addr_d = cur_addr_q + ADDR_W'(bytes);
            beat_cnt_d = '0;
            state_d    = ST_FILL;
            if (last_seg_q) begin
              busy_d        = 1'b0;
              frame_start_d = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q       <= ST_FILL;
      rdy_en_q      <= 1'b0;
      frame_start_q <= 1'b1;
      busy_q        <= 1'b0;
      last_seg_q    <= 1'b0;
      beat_cnt_q    <= '0;
      out_idx_q     <= '0;
      seg_len_q     <= MAX_LEN;
      cur_addr_q    <= '0;
      srcdest_q     <= '0;
      pkt_cnt_q     <= '0;
      mode_q        <= '0;
      prio_q        <= '0;
      tid_q         <= '0;
    end else begin
      state_q       <= state_d;
      rdy_en_q      <= rdy_en_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      last_seg_q    <= last_seg_d;
      beat_cnt_q    <= beat_cnt_d;
      out_idx_q     <= out_idx_d;
      seg_len_q     <= seg_len_d;
      cur_addr_q    <= cur_addr_d;
      srcdest_q     <= srcdest_d;
      pkt_cnt_q     <= pkt_cnt_d;
      mode_q        <= mode_d;
      prio_q        <= prio_d;
      tid_q         <= tid_d;
    end
  end

  // Payload store has no reset; its contents are only read after being written.
  always_ff @(posedge AXIS_ACLK) begin
    if (wr_en) mem_q[beat_cnt_q[IDX_W-1:0]] <= s_axis.tdata;
  end

  assign m_axis.tuser   = srcdest_q;
  assign busy           = busy_q;
  assign stat_pkt_count = pkt_cnt_q;
endmodule

// File: tb/tb_srio_swrite_segmenter.sv
// tb/tb_srio_swrite_segmenter.sv - self-checking bench for srio_swrite_segmenter
module tb_srio_swrite_segmenter;
  typedef struct {
    logic [63:0] d;
    logic        l;
    logic [31:0] u;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [33:0] cfg_base_addr;
  logic [31:0] cfg_srcdest;
  logic [1:0]  cfg_mode;
  logic [1:0]  cfg_prio;
  logic [5:0]  cfg_seg_beats;
  logic        busy;
  logic [31:0] stat_pkt_count;

  srio_swrite_segmenter_if s_if ();
  srio_swrite_segmenter_if m_if ();

  srio_swrite_segmenter dut (
    .AXIS_ACLK      (clk),
    .AXIS_ARESETN   (rst_n),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_srcdest    (cfg_srcdest),
    .cfg_mode       (cfg_mode),
    .cfg_prio       (cfg_prio),
    .cfg_seg_beats  (cfg_seg_beats),
    .s_axis         (s_if),
    .m_axis         (m_if),
    .busy           (busy),
    .stat_pkt_count (stat_pkt_count)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          duty  = 100;
  beat_t       exp_q[$];
  beat_t       obs_q[$];
  logic [63:0] frame_q[$];
  logic [7:0]  m_tid  = 8'd0;
  int          m_pkts = 0;
  int          chg_idx = -1;
  logic [33:0] chg_base;
  logic [31:0] chg_sd;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    m_if.tready = ($urandom_range(99) < duty);
  end

  logic        stall_pend = 1'b0;
  logic [63:0] stall_d;
  logic        stall_l;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        chk("stall_tvalid", 64'(m_if.tvalid), 64'd1);
        chk("stall_tdata", m_if.tdata, stall_d);
        chk("stall_tlast", 64'(m_if.tlast), 64'(stall_l));
      end
      if (m_if.tvalid && m_if.tready) obs_q.push_back('{m_if.tdata, m_if.tlast, m_if.tuser});
      stall_pend = m_if.tvalid && !m_if.tready;
      stall_d    = m_if.tdata;
      stall_l    = m_if.tlast;
    end
  end

  // Reference: slice the frame into seg-sized chunks; each chunk's address is base + offset.
  task automatic model_frame(input int seg_cfg, input logic [33:0] base, input logic [1:0] mode,
                             input logic [1:0] prio, input logic [31:0] sd);
    int          n = frame_q.size();
    int          seg = (seg_cfg == 0 || seg_cfg > 32) ? 32 : seg_cfg;
    logic [3:0]  ft, tt;
    logic [63:0] a;
    logic [7:0]  sz;
    ft = (mode == 2'd1 || mode == 2'd2) ? 4'd5 : 4'd6;
    tt = (mode == 2'd1) ? 4'd4 : (mode == 2'd2) ? 4'd5 : 4'd0;
    for (int off = 0; off < n; off += seg) begin
      int beats = (n - off < seg) ? n - off : seg;
      a  = {30'd0, base} + 64'(off) * 64'd8;
      sz = 8'(beats * 8 - 1);
      exp_q.push_back('{{m_tid, ft, tt, 1'b0, prio, 1'b0, sz, 2'b00, a[33:0]}, 1'b0, sd});
      for (int j = 0; j < beats; j++) exp_q.push_back('{frame_q[off + j], (j == beats - 1), sd});
      m_tid++;
      m_pkts++;
    end
  endtask

  task automatic send_frame();
    int n = frame_q.size();
    for (int i = 0; i < n; i++) begin
      int   c  = 0;
      logic hs = 1'b0;
      s_if.tdata  = frame_q[i];
      s_if.tvalid = 1'b1;
      s_if.tlast  = (i == n - 1);
      while (!hs && c < 5000) begin
        @(negedge clk);
        hs = s_if.tready;
        @(posedge clk);
        #1;
        c++;
      end
      if (!hs) begin
        chk("in_timeout", 64'd0, 64'd1);
        break;
      end
      if (i == chg_idx) begin
        cfg_base_addr = chg_base;
        cfg_srcdest   = chg_sd;
      end
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic do_frame(input int n, input int seg, input logic [33:0] base, input logic [1:0] mode,
                          input logic [1:0] prio, input logic [31:0] sd, input bit seq);
    cfg_seg_beats = 6'(seg);
    cfg_base_addr = base;
    cfg_mode      = mode;
    cfg_prio      = prio;
    cfg_srcdest   = sd;
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(seq ? 64'(i + 1) : {$urandom, $urandom});
    model_frame(seg, base, mode, prio, sd);
    send_frame();
  endtask

  task automatic wait_out(input int n);
    int c = 0;
    while (obs_q.size() < n && c < 20000) begin
      @(negedge clk);
      #1;
      c++;
    end
  endtask

  task automatic compare_all(input string tag);
    int n;
    wait_out(exp_q.size());
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), obs_q[i].d, exp_q[i].d);
      chk($sformatf("%s_last%0d", tag, i), 64'(obs_q[i].l), 64'(exp_q[i].l));
      chk($sformatf("%s_user%0d", tag, i), 64'(obs_q[i].u), 64'(exp_q[i].u));
    end
    chk({tag, "_pkts"}, 64'(stat_pkt_count), 64'(m_pkts));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst_n         = 1'b0;
    s_if.tvalid   = 1'b0;
    s_if.tlast    = 1'b0;
    s_if.tdata    = '0;
    s_if.tuser    = '0;
    m_if.tready   = 1'b0;
    cfg_base_addr = '0;
    cfg_srcdest   = '0;
    cfg_mode      = '0;
    cfg_prio      = '0;
    cfg_seg_beats = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_tlast", 64'(m_if.tlast), 64'd0);
    chk("rst_tdata", m_if.tdata, 64'd0);
    chk("rst_tuser", 64'(m_if.tuser), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pkts", 64'(stat_pkt_count), 64'd0);
    chk("rst_tready", 64'(s_if.tready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_tready0", 64'(s_if.tready), 64'd0);
    @(posedge clk);
    #1;
    chk("rel_tready1", 64'(s_if.tready), 64'd1);

    // 10 beats at 4 per packet
    duty = 100;
    do_frame(10, 4, 34'h1_0000_0000, 2'd0, 2'd0, 32'h0012_0034, 1'b1);
    wait_out(1);
    chk("t1_hdr0_const", obs_q[0].d, 64'h0060_01F1_0000_0000);
    compare_all("t1");
    chk("t1_pkt3", 64'(stat_pkt_count), 64'd3);

    // full 32-beat packet, NWRITE_R
    do_frame(32, 0, 34'h0_0000_1000, 2'd2, 2'd3, 32'hABCD_1234, 1'b0);
    wait_out(33);
    chk("t2_busy_before", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    chk("t2_busy_after", 64'(busy), 64'd0);
    compare_all("t2");

    // random frames under backpressure
    duty = 30;
    for (int f = 0; f < 3; f++)
      do_frame($urandom_range(1, 100), $urandom_range(0, 40), {2'($urandom), 32'($urandom)},
               2'($urandom), 2'($urandom), 32'($urandom), 1'b0);
    compare_all("rnd");

    // address wrap
    duty = 100;
    do_frame(8, 4, 34'h3_FFFF_FFF0, 2'd1, 2'd1, 32'h5555_AAAA, 1'b1);
    compare_all("wrap");

    // cfg change mid-frame
    chg_idx  = 2;
    chg_base = 34'h0_2000_0000;
    chg_sd   = 32'h7777_8888;
    do_frame(6, 4, 34'h0_1000_0000, 2'd0, 2'd2, 32'h1111_2222, 1'b1);
    chg_idx = -1;
    do_frame(3, 4, chg_base, 2'd0, 2'd2, chg_sd, 1'b1);
    compare_all("chg");

    // reset during DATA beat 2 of 4
    do_frame(4, 4, 34'h0_0000_0400, 2'd0, 2'd0, 32'h0F0F_0F0F, 1'b1);
    wait_out(2);
    @(posedge clk);
    #1;
    chk("mid_tvalid_pre", 64'(m_if.tvalid), 64'd1);
    chk("mid_tdata_pre", m_if.tdata, exp_q[2].d);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_pkts", 64'(stat_pkt_count), 64'd0);
    obs_q.delete();
    exp_q.delete();
    m_tid  = 8'd0;
    m_pkts = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_frame(1, 4, 34'h0_0000_0800, 2'd0, 2'd0, 32'h0000_0001, 1'b1);
    wait_out(1);
    chk("post_rst_hdr", obs_q[0].d, 64'h0060_0070_0000_0800);
    compare_all("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
